// File: rtl/lpf_channel_scheduler.sv
// Time-shares one low-pass filter engine across CHANNELS channels, one frame per sample tick.
// Latency: all-bypass frame CHANNELS+2 cycles tick->data_valid_o; each enabled channel adds ISSUE+WAIT time.
// Backpressure: eng_valid_o/eng_chan_o/eng_data_o held until eng_ready_i; ticks while busy only set overrun_o.
module lpf_channel_scheduler #(
    parameter int DWIDTH   = 16,
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         sample_tick_i,
    input  logic [CHANNELS-1:0]          enable_i,
    input  logic [CHANNELS*DWIDTH-1:0]   data_i,
    output logic                         eng_valid_o,
    input  logic                         eng_ready_i,
    output logic [$clog2(CHANNELS)-1:0]  eng_chan_o,
    output logic [DWIDTH-1:0]            eng_data_o,
    input  logic                         eng_res_valid_i,
    input  logic [DWIDTH-1:0]            eng_res_i,
    output logic [CHANNELS*DWIDTH-1:0]   data_o,
    output logic                         data_valid_o,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic                         timeout_o
);

    localparam int CW = $clog2(CHANNELS);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]          state_q;
    logic [CW-1:0]       chan_q;
    logic [WW-1:0]       wdog_q;
    logic [CHANNELS-1:0] en_q;
    logic [DWIDTH-1:0]   sample_q [CHANNELS];
    logic [DWIDTH-1:0]   slot_q   [CHANNELS];
    logic                last_ch;

    assign last_ch     = (chan_q == LAST_CH);
    assign eng_valid_o = (state_q == ST_ISSUE);
    assign eng_chan_o  = chan_q;
    assign eng_data_o  = sample_q[chan_q];
    assign busy_o      = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            chan_q       <= '0;
            wdog_q       <= '0;
            en_q         <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                sample_q[c] <= '0;
                slot_q[c]   <= '0;
            end
        end else begin
            data_valid_o <= 1'b0;
            // Ticks outside IDLE (including the DONE cycle) are never captured.
            if (sample_tick_i && (state_q != ST_IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sample_tick_i) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            sample_q[c] <= data_i[c*DWIDTH +: DWIDTH];
                        end
                        en_q    <= enable_i;
                        chan_q  <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (en_q[chan_q]) begin
                        state_q <= ST_ISSUE;
                    end else begin
                        slot_q[chan_q] <= sample_q[chan_q];
                        state_q        <= last_ch ? ST_DONE : ST_SCAN;
                        chan_q         <= last_ch ? chan_q : chan_q + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (eng_ready_i) begin
                        wdog_q  <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_res_valid_i) begin
                        slot_q[chan_q] <= eng_res_i;
                        state_q        <= last_ch ? ST_DONE : ST_SCAN;
                        chan_q         <= last_ch ? chan_q : chan_q + 1'b1;
                    end else if (wdog_q == WDOG_LAST) begin
                        // Engine went silent: pass the raw sample through so the frame still completes.
                        slot_q[chan_q] <= sample_q[chan_q];
                        timeout_o      <= 1'b1;
                        state_q        <= last_ch ? ST_DONE : ST_SCAN;
                        chan_q         <= last_ch ? chan_q : chan_q + 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        data_o[c*DWIDTH +: DWIDTH] <= slot_q[c];
                    end
                    data_valid_o <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Directed bench for lpf_channel_scheduler at default parameters (4 x 16-bit channels, TIMEOUT 64).
module tb_lpf_channel_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        sample_tick_i;
    logic [3:0]  enable_i;
    logic [63:0] data_i;
    logic        eng_valid_o;
    logic        eng_ready_i;
    logic [1:0]  eng_chan_o;
    logic [15:0] eng_data_o;
    logic        eng_res_valid_i;
    logic [15:0] eng_res_i;
    logic [63:0] data_o;
    logic        data_valid_o;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_pass   = 0;

    lpf_channel_scheduler dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .sample_tick_i  (sample_tick_i),
        .enable_i       (enable_i),
        .data_i         (data_i),
        .eng_valid_o    (eng_valid_o),
        .eng_ready_i    (eng_ready_i),
        .eng_chan_o     (eng_chan_o),
        .eng_data_o     (eng_data_o),
        .eng_res_valid_i(eng_res_valid_i),
        .eng_res_i      (eng_res_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_tick(input logic [63:0] d, input logic [3:0] en);
        data_i        = d;
        enable_i      = en;
        sample_tick_i = 1'b1;
        step();
        sample_tick_i = 1'b0;
    endtask

    // Engine model: accepts whenever ready, answers input+1 'delay' cycles after the accept,
    // except for channels set in nomask. Counts cycles relative to the call (first cycle = 1).
    task automatic run_frame(input int budget, input int delay, input logic [3:0] nomask,
                             output int first_vld, output int n_vld, output int n_eng);
        logic        pend;
        int          wcnt;
        logic [15:0] pdat;
        pend = 1'b0; wcnt = 0; pdat = '0;
        first_vld = 0; n_vld = 0; n_eng = 0;
        eng_ready_i = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            eng_res_valid_i = 1'b0;
            if (pend) begin
                wcnt++;
                if (wcnt == delay) begin
                    eng_res_valid_i = 1'b1;
                    eng_res_i       = pdat;
                    pend            = 1'b0;
                end
            end
            if (eng_valid_o) begin
                n_eng++;
                if (eng_ready_i && !nomask[eng_chan_o]) begin
                    pend = 1'b1;
                    wcnt = 0;
                    pdat = eng_data_o + 16'd1;
                end
            end
            if (data_valid_o) begin
                n_vld++;
                if (first_vld == 0) first_vld = i;
            end
            step();
        end
        eng_res_valid_i = 1'b0;
    endtask

    initial begin
        int fv, nv, ne;
        rst_n_i         = 1'b0;
        sample_tick_i   = 1'b0;
        enable_i        = '0;
        data_i          = '0;
        eng_ready_i     = 1'b0;
        eng_res_valid_i = 1'b0;
        eng_res_i       = '0;
        step();
        step();
        chk("rst_data_o", data_o, 64'h0);
        chk("rst_flags", {59'h0, busy_o, data_valid_o, eng_valid_o, overrun_o, timeout_o}, 64'h0);
        rst_n_i = 1'b1;
        step();

        // All channels filtered, engine answers two cycles after accept
        do_tick(64'h0040_0030_0020_0010, 4'b1111);
        run_frame(30, 2, 4'b0000, fv, nv, ne);
        chk("t1_data", data_o, 64'h0041_0031_0021_0011);
        chk("t1_nvalid", 64'(nv), 64'd1);
        chk("t1_latency", 64'(fv), 64'd18);
        chk("t1_requests", 64'(ne), 64'd4);
        chk("t1_sticky", {62'h0, overrun_o, timeout_o}, 64'h0);

        // All bypass
        do_tick(64'h1234_1234_1234_1234, 4'b0000);
        run_frame(15, 2, 4'b0000, fv, nv, ne);
        chk("t2_data", data_o, 64'h1234_1234_1234_1234);
        chk("t2_latency", 64'(fv), 64'd6);
        chk("t2_nvalid", 64'(nv), 64'd1);
        chk("t2_no_eng_valid", 64'(ne), 64'd0);

        // Engine backpressure on channel 2
        eng_ready_i = 1'b0;
        do_tick(64'h0400_0300_0200_0100, 4'b0100);
        for (int i = 0; i < 8 && !eng_valid_o; i++) step();
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold", {45'h0, eng_valid_o, eng_chan_o, eng_data_o}, {45'h0, 1'b1, 2'd2, 16'h0300});
            step();
        end
        run_frame(15, 2, 4'b0000, fv, nv, ne);
        chk("t3_latency", 64'(fv), 64'd6);
        chk("t3_requests", 64'(ne), 64'd1);
        chk("t3_nvalid", 64'(nv), 64'd1);
        chk("t3_data", data_o, 64'h0400_0301_0200_0100);

        // Channel 1 never answered -> watchdog passes raw sample through
        do_tick(64'h0444_0333_0222_0111, 4'b1111);
        run_frame(120, 2, 4'b0010, fv, nv, ne);
        chk("t4_data", data_o, 64'h0445_0334_0222_0112);
        chk("t4_latency", 64'(fv), 64'd80);
        chk("t4_nvalid", 64'(nv), 64'd1);
        chk("t4_timeout", {63'h0, timeout_o}, 64'h1);

        // Second tick while busy
        data_i        = 64'h0A04_0A03_0A02_0A01;
        enable_i      = 4'b0000;
        sample_tick_i = 1'b1;
        step();
        chk("t5_overrun_pre", {63'h0, overrun_o}, 64'h0);
        data_i = 64'h0B04_0B03_0B02_0B01;
        step();
        sample_tick_i = 1'b0;
        run_frame(20, 2, 4'b0000, fv, nv, ne);
        chk("t5_overrun", {63'h0, overrun_o}, 64'h1);
        chk("t5_data", data_o, 64'h0A04_0A03_0A02_0A01);
        chk("t5_latency", 64'(fv), 64'd5);
        chk("t5_nvalid", 64'(nv), 64'd1);

        // Tick coincident with the DONE cycle is not captured
        do_tick(64'h0C04_0C03_0C02_0C01, 4'b0000);
        for (int i = 0; i < 4; i++) step();
        chk("t5b_busy_done", {63'h0, busy_o}, 64'h1);
        data_i        = 64'h0D04_0D03_0D02_0D01;
        sample_tick_i = 1'b1;
        step();
        sample_tick_i = 1'b0;
        chk("t5b_valid", {63'h0, data_valid_o}, 64'h1);
        chk("t5b_not_captured", {63'h0, busy_o}, 64'h0);
        chk("t5b_data", data_o, 64'h0C04_0C03_0C02_0C01);

        // Reset while waiting on channel 2
        do_tick(64'h0E04_0E03_0E02_0E01, 4'b1111);
        run_frame(12, 2, 4'b0100, fv, nv, ne);
        chk("t6_in_wait", {61'h0, busy_o, eng_chan_o}, {61'h0, 1'b1, 2'd2});
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_data", data_o, 64'h0);
        chk("t6_rst_flags", {59'h0, busy_o, data_valid_o, eng_valid_o, overrun_o, timeout_o}, 64'h0);
        @(posedge clk_i);
        #1;
        rst_n_i         = 1'b1;
        eng_res_valid_i = 1'b1;
        eng_res_i       = 16'hBEEF;
        step();
        eng_res_valid_i = 1'b0;
        chk("t6_late_res_busy", {63'h0, busy_o}, 64'h0);
        chk("t6_late_res_data", data_o, 64'h0);
        step();
        chk("t6_late_res_valid", {63'h0, data_valid_o}, 64'h0);
        do_tick(64'h0F04_0F03_0F02_0F01, 4'b0001);
        run_frame(15, 2, 4'b0000, fv, nv, ne);
        chk("t6_next_data", data_o, 64'h0F04_0F03_0F02_0F02);
        chk("t6_next_latency", 64'(fv), 64'd9);
        chk("t6_next_nvalid", 64'(nv), 64'd1);
        chk("t6_next_sticky", {62'h0, overrun_o, timeout_o}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
